// File: rtl/ped_crossing_fsm.sv
// Pedestrian-crossing light controller: tick-timed GREEN/YELLOW/CLEAR/WALK/FLASH cycle.
// Latency: ped_req reaches ped_pending after 3 clk edges; outputs are registered-state decodes.
// Backpressure: none; the timer advances only on tick, so state and timer hold while tick is low.
module ped_crossing_fsm #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int CLEAR_TICKS  = 1,
  parameter int WALK_TICKS   = 6,
  parameter int FLASH_TICKS  = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       tick,
  input  logic       ped_req,
  output logic       main_g,
  output logic       main_y,
  output logic       main_r,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  localparam logic [2:0] ST_GREEN  = 3'd0;
  localparam logic [2:0] ST_YELLOW = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_WALK   = 3'd3;
  localparam logic [2:0] ST_FLASH  = 3'd4;

  // Timer reload values: each state runs for exactly its *_TICKS ticks.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_TICKS - 1);

  logic [2:0]       cur_state, nxt_state;
  logic [CNT_W-1:0] timer, nxt_timer;
  logic             pending, nxt_pending;
  logic             flash, nxt_flash;
  logic             sync1, sync2;
  logic             legal;
  logic             req_set, req_clr;

  // State, timer, request latch, flash phase and button synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cur_state <= ST_GREEN;
      timer     <= GREEN_LD;
      pending   <= 1'b0;
      flash     <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      timer     <= nxt_timer;
      pending   <= nxt_pending;
      flash     <= nxt_flash;
      sync1     <= ped_req;
      sync2     <= sync1;
    end
  end

  // Next-state, timer reload/decrement, flash phase and request latch update.
  always_comb begin
    nxt_state = cur_state;
    nxt_timer = timer;
    nxt_flash = flash;
    legal     = (cur_state <= ST_FLASH);

    if (!legal) begin
      nxt_state = ST_GREEN;
      nxt_timer = GREEN_LD;
    end else if (tick) begin
      if (timer != '0) begin
        nxt_timer = timer - CNT_W'(1);
      end else begin
        case (cur_state)
          ST_GREEN: begin
            // Minimum green is served; wait here (timer parked at 0) for a request.
            if (pending) begin
              nxt_state = ST_YELLOW;
              nxt_timer = YELLOW_LD;
            end
          end
          ST_YELLOW: begin
            nxt_state = ST_CLEAR;
            nxt_timer = CLEAR_LD;
          end
          ST_CLEAR: begin
            nxt_state = ST_WALK;
            nxt_timer = WALK_LD;
          end
          ST_WALK: begin
            nxt_state = ST_FLASH;
            nxt_timer = FLASH_LD;
          end
          ST_FLASH: begin
            nxt_state = ST_GREEN;
            nxt_timer = GREEN_LD;
          end
          default: begin
            nxt_state = ST_GREEN;
            nxt_timer = GREEN_LD;
          end
        endcase
      end
    end

    if (cur_state == ST_FLASH && tick)
      nxt_flash = ~flash;
    if (cur_state != ST_FLASH && nxt_state == ST_FLASH)
      nxt_flash = 1'b1;

    // Level-sensitive set means a held button re-arms only once WALK is over.
    req_set = sync2 && (cur_state == ST_GREEN || cur_state == ST_YELLOW ||
                        cur_state == ST_CLEAR || cur_state == ST_FLASH);
    req_clr = (cur_state != ST_WALK) && (nxt_state == ST_WALK);
    nxt_pending = req_clr ? 1'b0 : (pending | req_set);
  end

  // Moore lamp decode from registered state and flash phase.
  always_comb begin
    main_g    = 1'b0;
    main_y    = 1'b0;
    main_r    = 1'b0;
    walk      = 1'b0;
    dont_walk = 1'b0;
    case (cur_state)
      ST_GREEN: begin
        main_g    = 1'b1;
        dont_walk = 1'b1;
      end
      ST_YELLOW: begin
        main_y    = 1'b1;
        dont_walk = 1'b1;
      end
      ST_CLEAR: begin
        main_r    = 1'b1;
        dont_walk = 1'b1;
      end
      ST_WALK: begin
        main_r = 1'b1;
        walk   = 1'b1;
      end
      ST_FLASH: begin
        main_r    = 1'b1;
        dont_walk = flash;
      end
      default: begin
        // Illegal code lasts one clk; show the safe all-stop aspect meanwhile.
        main_r    = 1'b1;
        dont_walk = 1'b1;
      end
    endcase
  end

  assign state       = cur_state;
  assign ped_pending = pending;

endmodule

// File: tb/tb_ped_crossing_fsm.sv
// Directed stimulus with a scoreboard queue of expected lamp/state vectors.
// Each stimulus cycle pushes the expected outputs after the next rising edge.
// A separate monitor pops and compares one entry per edge.
module tb_ped_crossing_fsm;

  logic       clk;
  logic       rstb;
  logic       tick;
  logic       ped_req;
  logic       main_g, main_y, main_r, walk, dont_walk, ped_pending;
  logic [2:0] state;

  localparam logic [2:0] G = 3'd0;
  localparam logic [2:0] Y = 3'd1;
  localparam logic [2:0] C = 3'd2;
  localparam logic [2:0] W = 3'd3;
  localparam logic [2:0] F = 3'd4;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];

  ped_crossing_fsm dut (
    .clk        (clk),
    .rstb       (rstb),
    .tick       (tick),
    .ped_req    (ped_req),
    .main_g     (main_g),
    .main_y     (main_y),
    .main_r     (main_r),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .ped_pending(ped_pending),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector {state, g, y, r, walk, dont_walk, pending} for a legal state.
  function automatic logic [8:0] expect_vec(input logic [2:0] st, input logic dw, input logic pd);
    logic g, y, r, wk, dwo;
    g   = (st == G);
    y   = (st == Y);
    r   = (st == C) || (st == W) || (st == F);
    wk  = (st == W);
    dwo = (st == F) ? dw : (st != W);
    return {st, g, y, r, wk, dwo, pd};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic step(input logic t, input logic r, input logic rb,
                      input logic [2:0] st, input logic dw, input logic pd, input string nm);
    @(negedge clk);
    tick    = t;
    ped_req = r;
    rstb    = rb;
    exp_q.push_back(expect_vec(st, dw, pd));
    name_q.push_back(nm);
  endtask

  task automatic steps(input int n, input logic t, input logic r, input logic rb,
                       input logic [2:0] st, input logic dw, input logic pd, input string nm);
    for (int i = 0; i < n; i++) step(t, r, rb, st, dw, pd, nm);
  endtask

  // Monitor: compare the DUT against the oldest expectation just after each edge.
  initial begin
    logic [8:0] e, act;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state, main_g, main_y, main_r, walk, dont_walk, ped_pending};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s @%0t: got st/g/y/r/w/dw/pend=%b expected %b", nm, $time, act, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb    = 1'b0;
    tick    = 1'b0;
    ped_req = 1'b0;

    // Reset with tick and ped_req active, then request latches on the 3rd edge.
    steps(2, 1'b1, 1'b1, 1'b0, G, 1'b1, 1'b0, "reset_hold");
    steps(2, 1'b0, 1'b1, 1'b1, G, 1'b1, 1'b0, "req_sync");
    step (1'b0, 1'b1, 1'b1, G, 1'b1, 1'b1, "req_latch3");

    // Full cycle with a 1-clk request pulse at clk 2 after reset.
    step (1'b1, 1'b0, 1'b0, G, 1'b1, 1'b0, "full_rst");
    step (1'b1, 1'b0, 1'b1, G, 1'b1, 1'b0, "full_green");
    step (1'b1, 1'b1, 1'b1, G, 1'b1, 1'b0, "full_green");
    step (1'b1, 1'b0, 1'b1, G, 1'b1, 1'b0, "full_green");
    steps(4, 1'b1, 1'b0, 1'b1, G, 1'b1, 1'b1, "full_green_pend");
    steps(3, 1'b1, 1'b0, 1'b1, Y, 1'b1, 1'b1, "full_yellow");
    step (1'b1, 1'b0, 1'b1, C, 1'b1, 1'b1, "full_clear");
    steps(6, 1'b1, 1'b0, 1'b1, W, 1'b0, 1'b0, "full_walk");
    step (1'b1, 1'b0, 1'b1, F, 1'b1, 1'b0, "full_flash0");
    step (1'b1, 1'b0, 1'b1, F, 1'b0, 1'b0, "full_flash1");
    step (1'b1, 1'b0, 1'b1, F, 1'b1, 1'b0, "full_flash2");
    step (1'b1, 1'b0, 1'b1, F, 1'b0, 1'b0, "full_flash3");
    step (1'b1, 1'b0, 1'b1, G, 1'b1, 1'b0, "full_back_green");

    // Idle green: no request, green holds indefinitely.
    step (1'b1, 1'b0, 1'b0, G, 1'b1, 1'b0, "idle_rst");
    steps(40, 1'b1, 1'b0, 1'b1, G, 1'b1, 1'b0, "idle_green");

    // Late request: YELLOW on the 4th edge after the pulse.
    step (1'b1, 1'b1, 1'b1, G, 1'b1, 1'b0, "late_pulse");
    step (1'b1, 1'b0, 1'b1, G, 1'b1, 1'b0, "late_sync");
    step (1'b1, 1'b0, 1'b1, G, 1'b1, 1'b1, "late_pend");
    step (1'b1, 1'b0, 1'b1, Y, 1'b1, 1'b1, "late_yellow");

    // Tick every 4th clk: YELLOW lasts 12 clks in total.
    for (int i = 0; i < 12; i++)
      step((i % 4) == 3, 1'b0, 1'b1, (i == 11) ? C : Y, 1'b1, 1'b1, "gate_yellow");

    // Button held through WALK: ignored until FLASH.
    step (1'b1, 1'b1, 1'b1, W, 1'b0, 1'b0, "hold_walk_entry");
    steps(5, 1'b1, 1'b1, 1'b1, W, 1'b0, 1'b0, "hold_walk");
    step (1'b1, 1'b1, 1'b1, F, 1'b1, 1'b0, "hold_flash_entry");
    step (1'b1, 1'b1, 1'b1, F, 1'b0, 1'b1, "hold_flash_rearm");
    step (1'b1, 1'b1, 1'b1, F, 1'b1, 1'b1, "hold_flash");
    step (1'b1, 1'b1, 1'b1, F, 1'b0, 1'b1, "hold_flash");
    step (1'b1, 1'b1, 1'b1, G, 1'b1, 1'b1, "rearm_green");

    // Re-armed request serves another cycle; reset lands mid-WALK.
    steps(7, 1'b1, 1'b0, 1'b1, G, 1'b1, 1'b1, "rearm_green");
    steps(3, 1'b1, 1'b0, 1'b1, Y, 1'b1, 1'b1, "rearm_yellow");
    step (1'b1, 1'b0, 1'b1, C, 1'b1, 1'b1, "rearm_clear");
    steps(2, 1'b1, 1'b0, 1'b1, W, 1'b0, 1'b0, "rearm_walk");
    step (1'b1, 1'b1, 1'b0, G, 1'b1, 1'b0, "midwalk_reset");
    step (1'b0, 1'b0, 1'b1, G, 1'b1, 1'b0, "after_reset");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_crossing_fsm.md
Name: ped_crossing_fsm

Overview:
- Pedestrian-crossing traffic-light controller for the state-machine lab.
- Next-state and timer logic drive a registered 3-bit state vector. The light and walk outputs are decoded from that state.
- Sits between the board pushbutton/prescaler inputs and the LED outputs.
- Its state register is the consumer of the team's D flip-flop stage. Every state and timer bit is a positive-edge register on clk.

Parameters:
- GREEN_TICKS, 8, minimum main-road green duration in ticks (≥1)
- YELLOW_TICKS, 3, main-road yellow duration in ticks (≥1)
- CLEAR_TICKS, 1, all-red clearance duration in ticks (≥1)
- WALK_TICKS, 6, steady walk duration in ticks (≥1)
- FLASH_TICKS, 4, flashing don't-walk duration in ticks (≥1)
- CNT_W, 4, timer width; must hold max(*_TICKS)-1

Ports:
- clk  input  1  system clock; all registers update on the rising edge
- rstb  input  1  synchronous active-low reset, sampled on the rising edge of clk
- tick  input  1  one-clk-wide enable pulse from the prescaler; the timer advances only when high
- ped_req  input  1  raw pushbutton, asynchronous to clk
- main_g  output  1  main-road green lamp
- main_y  output  1  main-road yellow lamp
- main_r  output  1  main-road red lamp
- walk  output  1  pedestrian walk lamp
- dont_walk  output  1  pedestrian don't-walk lamp
- ped_pending  output  1  latched, not-yet-served pedestrian request
- state  output  3  encoded current state, for debug/LEDs

Behaviour:
- Reset (rstb=0 at a clk edge):
  - state=GREEN(0), timer=GREEN_TICKS-1, ped_pending=0, synchronizer flops=0, flash phase=0.
  - Resulting outputs: main_g=1, dont_walk=1, all other outputs 0.
  - Reset overrides tick and ped_req and takes effect mid-state.
- States and encoding: GREEN=0, YELLOW=1, CLEAR=2, WALK=3, FLASH=4. Codes 5-7 are illegal and go to GREEN with a timer reload on the next clk.
- Outputs: Moore, decoded from registered state/phase only; no path from inputs.
  - GREEN: main_g=1.
  - YELLOW: main_y=1.
  - CLEAR, WALK, FLASH: main_r=1.
  - walk=1 only in WALK.
  - dont_walk=1 in GREEN, YELLOW and CLEAR. In FLASH, dont_walk=flash phase.
- Timer:
  - On entry to a state, the timer loads that state's *_TICKS-1.
  - On tick with timer≠0: decrement.
  - On tick with timer=0: evaluate the transition.
  - Each state therefore lasts exactly *_TICKS ticks. GREEN may last longer.
  - With tick=0, timer and state hold.
- Transitions, evaluated on tick with timer=0:
  - GREEN→YELLOW if ped_pending=1. Otherwise stay in GREEN with timer held at 0, and leave on the first tick where ped_pending=1.
  - YELLOW→CLEAR.
  - CLEAR→WALK.
  - WALK→FLASH.
  - FLASH→GREEN.
- Flash phase:
  - Set to 1 on entry to FLASH.
  - Toggles on every tick while in FLASH.
- Request path:
  - ped_req passes through a 2-flop synchronizer.
  - ped_pending is set on the clk after the synchronized value is 1, i.e. 3 clk edges after ped_req rises.
  - It is set in GREEN, YELLOW, CLEAR and FLASH. Requests during WALK are ignored.
  - ped_pending clears on the clk that enters WALK.
  - A simultaneous set and clear resolves to clear.
  - A held button does not re-arm until the state reaches FLASH.
- No counter wrap: the timer never decrements below 0.

Test Plan:
- Reset: hold rstb=0 for 2 clks with tick=1, ped_req=1 → state=0, main_g=1, dont_walk=1, ped_pending=0. After release, ped_pending=1 at the 3rd clk.
- Idle green: tick every clk, ped_req=0 for 40 clks → state stays 0, main_g=1 throughout.
- Full cycle (tick every clk, defaults, 1-clk ped_req pulse at clk 2 after reset):
  - GREEN lasts 8 clks.
  - YELLOW lasts 3 clks with main_y=1.
  - CLEAR lasts 1 clk.
  - WALK lasts 6 clks with walk=1 and ped_pending=0.
  - FLASH lasts 4 clks with dont_walk=1,0,1,0.
  - Then state=0.
- Late request: ped_req pulse at clk 30 of idle green → YELLOW entered on the tick following ped_pending=1, i.e. 4 clks after the pulse.
- Tick gating: tick once every 4 clks during YELLOW → YELLOW lasts exactly 12 clks. State and timer hold between ticks.
- Walk-ignore and mid-op reset: ped_req high throughout WALK → ped_pending stays 0 until FLASH, then sets. rstb=0 during WALK → next clk state=0, walk=0, main_g=1.
